uart_cmd_sequencer: RTL and testbench

- Framed command controller between uart_rx/uart_tx and the combinational ALU.
- Parses fixed-length request frames from the RX byte stream and validates the checksum and opcode.
- Fires the ALU for one cycle and captures its result.
- Sends back a 3-byte response frame through the TX start/done handshake.
- Half-duplex: while a response is in flight, new RX bytes are dropped.

---
 rtl/uart_cmd_sequencer.sv | 177 +++++++++++++++++
 tb/tb_uart_cmd_sequencer.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_sequencer.sv
// Framed command sequencer between uart_rx/uart_tx and a combinational ALU.
// Optional inter-byte timeout is enabled with the UART_SEQ_TIMEOUT_EN macro.
module uart_cmd_sequencer #(
  parameter int unsigned          NB_DATA       = 8,
  parameter int unsigned          NB_OP         = 6,
  parameter logic [NB_DATA-1:0]   SOF_REQ       = 8'hA5,
  parameter logic [NB_DATA-1:0]   SOF_RSP       = 8'h5A,
  parameter int unsigned          TIMEOUT_TICKS = 4096,
  parameter int unsigned          NB_TIMEOUT    = 13
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_tick,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_alu_valid,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic               o_busy,
  output logic               o_frame_err,
  output logic [3:0]         o_dbg_state
);

  // Handshakes: an RX byte is consumed only in a cycle where i_rx_done is high and
  // the FSM is in a receive state; o_tx_start pulses once per byte and o_tx_data is
  // held until the matching i_tx_done, which is only honoured in a WAIT state.

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_GET_OP    = 4'd1,
    S_GET_A     = 4'd2,
    S_GET_B     = 4'd3,
    S_GET_CHK   = 4'd4,
    S_EXEC      = 4'd5,
    S_TX_SOF    = 4'd6,
    S_WAIT_SOF  = 4'd7,
    S_TX_STAT   = 4'd8,
    S_WAIT_STAT = 4'd9,
    S_TX_RES    = 4'd10,
    S_WAIT_RES  = 4'd11
  } state_t;

  localparam logic [NB_DATA-1:0] ST_OK     = '0;
  localparam logic [NB_DATA-1:0] ST_BADCHK = NB_DATA'(1);
  localparam logic [NB_DATA-1:0] ST_BADOP  = NB_DATA'(2);

  if ((2 ** NB_TIMEOUT) <= TIMEOUT_TICKS) begin : g_bad_cfg
    $error("NB_TIMEOUT too narrow for TIMEOUT_TICKS");
  end

  state_t             state_q, state_d;
  logic [NB_DATA-1:0] op_q, a_q, b_q, chk_q, result_q, status_q;
  logic               chk_bad, op_bad, timeout;

  assign chk_bad = (op_q ^ a_q ^ b_q) != i_rx_data;
  assign op_bad  = |op_q[NB_DATA-1:NB_OP];

`ifdef UART_SEQ_TIMEOUT_EN
  logic [NB_TIMEOUT-1:0] cnt_q;
  logic                  in_get;

  assign in_get  = (state_q == S_GET_OP) || (state_q == S_GET_A) ||
                   (state_q == S_GET_B)  || (state_q == S_GET_CHK);
  // A byte arriving in the same cycle as the limiting tick still wins.
  assign timeout = in_get && i_tick && !i_rx_done &&
                   (cnt_q == NB_TIMEOUT'(TIMEOUT_TICKS - 1));

  always_ff @(posedge clk) begin
    if (i_rst || !in_get || i_rx_done || timeout) begin
      cnt_q <= '0;
    end else if (i_tick) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  logic unused_tick;
  assign timeout     = 1'b0;
  assign unused_tick = i_tick;
`endif

  logic unused_chk;
  assign unused_chk = ^chk_q;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (i_rx_done && (i_rx_data == SOF_REQ)) state_d = S_GET_OP;
      S_GET_OP:    if (i_rx_done) state_d = S_GET_A;
      S_GET_A:     if (i_rx_done) state_d = S_GET_B;
      S_GET_B:     if (i_rx_done) state_d = S_GET_CHK;
      S_GET_CHK:   if (i_rx_done) state_d = (chk_bad || op_bad) ? S_TX_SOF : S_EXEC;
      S_EXEC:      state_d = S_TX_SOF;
      S_TX_SOF:    state_d = S_WAIT_SOF;
      S_WAIT_SOF:  if (i_tx_done) state_d = S_TX_STAT;
      S_TX_STAT:   state_d = S_WAIT_STAT;
      S_WAIT_STAT: if (i_tx_done) state_d = S_TX_RES;
      S_TX_RES:    state_d = S_WAIT_RES;
      S_WAIT_RES:  if (i_tx_done) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    if (timeout) state_d = S_IDLE;
  end

  always_comb begin
    o_tx_start  = 1'b0;
    o_tx_data   = '0;
    o_alu_valid = 1'b0;
    o_frame_err = 1'b0;
    case (state_q)
      S_GET_CHK:   o_frame_err = i_rx_done && (chk_bad || op_bad);
      S_EXEC:      o_alu_valid = 1'b1;
      S_TX_SOF:    begin o_tx_start = 1'b1; o_tx_data = SOF_RSP;  end
      S_WAIT_SOF:  o_tx_data = SOF_RSP;
      S_TX_STAT:   begin o_tx_start = 1'b1; o_tx_data = status_q; end
      S_WAIT_STAT: o_tx_data = status_q;
      S_TX_RES:    begin o_tx_start = 1'b1; o_tx_data = result_q; end
      S_WAIT_RES:  o_tx_data = result_q;
      default:     ;
    endcase
    if (timeout) o_frame_err = 1'b1;
  end

  // Frame fields and response registers; the ALU result is sampled in EXEC.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      chk_q    <= '0;
      result_q <= '0;
      status_q <= '0;
    end else begin
      if (i_rx_done) begin
        case (state_q)
          S_GET_OP: op_q <= i_rx_data;
          S_GET_A:  a_q  <= i_rx_data;
          S_GET_B:  b_q  <= i_rx_data;
          S_GET_CHK: begin
            chk_q <= i_rx_data;
            if (chk_bad) begin
              status_q <= ST_BADCHK;
              result_q <= '0;
            end else if (op_bad) begin
              status_q <= ST_BADOP;
              result_q <= '0;
            end
          end
          default: ;
        endcase
      end
      if (state_q == S_EXEC) begin
        result_q <= i_alu_result;
        status_q <= ST_OK;
      end
    end
  end

  assign o_busy      = (state_q != S_IDLE);
  assign o_alu_op    = op_q[NB_OP-1:0];
  assign o_alu_a     = a_q;
  assign o_alu_b     = b_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Self-checking bench for uart_cmd_sequencer: stimulus tasks, TX responder,
// scoreboard queue of expected response bytes and a frame-level reference model.
module tb_uart_cmd_sequencer;

  logic       clk = 1'b0;
  logic       i_rst, i_tick, i_rx_done, i_tx_done;
  logic [7:0] i_rx_data, i_alu_result, o_tx_data, o_alu_a, o_alu_b;
  logic [5:0] o_alu_op;
  logic       o_tx_start, o_alu_valid, o_busy, o_frame_err;
  logic [3:0] o_dbg_state;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         alu_cnt = 0;
  int         err_cnt = 0;
  int         tx_seen = 0;
  logic [5:0] exp_op = '0;
  logic [7:0] exp_a = '0;
  logic [7:0] exp_b = '0;
  bit         hold_chk_en = 1'b1;
  bit         tx_active = 1'b0;
  int         tx_dmin = 1;
  int         tx_dmax = 4;

  always #5 clk = ~clk;

  uart_cmd_sequencer #(.TIMEOUT_TICKS(32)) dut (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_tick       (i_tick),
    .i_rx_data    (i_rx_data),
    .i_rx_done    (i_rx_done),
    .i_tx_done    (i_tx_done),
    .o_tx_start   (o_tx_start),
    .o_tx_data    (o_tx_data),
    .o_alu_valid  (o_alu_valid),
    .o_alu_op     (o_alu_op),
    .o_alu_a      (o_alu_a),
    .o_alu_b      (o_alu_b),
    .i_alu_result (i_alu_result),
    .o_busy       (o_busy),
    .o_frame_err  (o_frame_err),
    .o_dbg_state  (o_dbg_state)
  );

  // Stand-in combinational ALU.
  function automatic logic [7:0] alu_fn(input logic [5:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      default: return a + 8'h01;
    endcase
  endfunction

  assign i_alu_result = alu_fn(o_alu_op, o_alu_a, o_alu_b);

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : alu_monitor
    forever begin
      @(negedge clk);
      if (o_frame_err === 1'b1) err_cnt++;
      if (o_alu_valid === 1'b1) begin
        alu_cnt++;
        checks++;
        if ({o_alu_op, o_alu_a, o_alu_b} !== {exp_op, exp_a, exp_b}) begin
          errors++;
          $display("FAIL alu_operands: got op=%02h a=%02h b=%02h, expected op=%02h a=%02h b=%02h",
                   o_alu_op, o_alu_a, o_alu_b, exp_op, exp_a, exp_b);
        end
      end
    end
  end

  // uart_tx model: takes each start, checks the byte against the scoreboard,
  // checks it is held with no new start, then answers with a done pulse.
  initial begin : tx_responder
    logic [7:0] cap;
    logic [7:0] expb;
    int d;
    i_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (o_tx_start === 1'b1) begin
        tx_active = 1'b1;
        cap = o_tx_data;
        tx_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected: got byte %02h, expected no transmission", cap);
        end else begin
          expb = exp_q.pop_front();
          if (cap !== expb) begin
            errors++;
            $display("FAIL tx_byte: got %02h, expected %02h", cap, expb);
          end
        end
        d = $urandom_range(tx_dmax, tx_dmin);
        repeat (d) begin
          @(negedge clk);
          if (hold_chk_en) begin
            checks++;
            if (o_tx_data !== cap || o_tx_start !== 1'b0) begin
              errors++;
              $display("FAIL tx_hold: got data=%02h start=%b, expected data=%02h start=0",
                       o_tx_data, o_tx_start, cap);
            end
          end
        end
        @(posedge clk); #1;
        i_tx_done = 1'b1;
        @(posedge clk); #1;
        i_tx_done = 1'b0;
        tx_active = 1'b0;
      end
    end
  end

  // Reference model: expected response of one complete request frame.
  task automatic model_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] chk, output bit good);
    good = 1'b0;
    exp_q.push_back(8'h5A);
    if ((op ^ a ^ b) != chk) begin
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h00);
    end else if (op > 8'h3F) begin
      exp_q.push_back(8'h02);
      exp_q.push_back(8'h00);
    end else begin
      good = 1'b1;
      exp_q.push_back(8'h00);
      exp_q.push_back(alu_fn(op[5:0], a, b));
      exp_op = op[5:0];
      exp_a  = a;
      exp_b  = b;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(posedge clk);
    @(posedge clk); #1;
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(posedge clk); #1;
    i_rx_done = 1'b0;
    i_rx_data = 8'($urandom);
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      i_tick = 1'b1;
      @(posedge clk); #1;
      i_tick = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((o_busy !== 1'b0 || tx_active || exp_q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL %s_idle: busy=%b pending=%0d after %0d cycles, expected idle",
               tag, o_busy, exp_q.size(), n);
    end
  endtask

  task automatic wait_seen(input int target, input string tag);
    int n;
    n = 0;
    while (tx_seen < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL %s_tx_progress: got %0d bytes sent, expected %0d", tag, tx_seen, target);
    end
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] chk, input int gap, input string tag);
    bit good;
    bit found;
    int alu0, err0, lat;
    model_frame(op, a, b, chk, good);
    alu0 = alu_cnt;
    err0 = err_cnt;
    send_byte(8'hA5, gap);
    send_byte(op, gap);
    send_byte(a, gap);
    send_byte(b, gap);
    send_byte(chk, gap);
    lat = 1;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (o_tx_start === 1'b1) found = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    checks++;
    if (!found || lat != (good ? 2 : 1)) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles (start seen=%b), expected %0d",
               tag, lat, found, good ? 2 : 1);
    end
    wait_idle(tag);
    checks++;
    if (alu_cnt - alu0 != (good ? 1 : 0)) begin
      errors++;
      $display("FAIL %s_alu_pulses: got %0d, expected %0d", tag, alu_cnt - alu0, good ? 1 : 0);
    end
    checks++;
    if (err_cnt - err0 != (good ? 0 : 1)) begin
      errors++;
      $display("FAIL %s_frame_err: got %0d pulse cycles, expected %0d",
               tag, err_cnt - err0, good ? 0 : 1);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    checks++;
    if ({o_tx_start, o_alu_valid, o_busy, o_frame_err} !== 4'b0000) begin
      errors++;
      $display("FAIL %s_ctrl: got start=%b valid=%b busy=%b err=%b, expected all 0",
               tag, o_tx_start, o_alu_valid, o_busy, o_frame_err);
    end
    checks++;
    if ({o_tx_data, o_alu_a, o_alu_b, 2'b00, o_alu_op} !== 32'h0) begin
      errors++;
      $display("FAIL %s_data: got tx=%02h op=%02h a=%02h b=%02h, expected all 0",
               tag, o_tx_data, o_alu_op, o_alu_a, o_alu_b);
    end
    checks++;
    if (o_dbg_state !== 4'd0) begin
      errors++;
      $display("FAIL %s_state: got %0d, expected 0 (IDLE)", tag, o_dbg_state);
    end
  endtask

  task automatic test_reset;
    i_rst = 1'b1;
    i_rx_done = 1'b1;
    i_rx_data = 8'hA5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk); #1;
    i_rst = 1'b0;
    i_rx_done = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_busy: got %b, expected 0", o_busy);
    end
  endtask

  task automatic test_good_frame;
    tx_dmin = 1; tx_dmax = 4;
    send_frame(8'h20, 8'h05, 8'h03, 8'h26, 0, "good");
  endtask

  task automatic test_bad_checksum;
    send_frame(8'h20, 8'h05, 8'h03, 8'h27, 1, "badchk");
  endtask

  task automatic test_bad_opcode;
    send_frame(8'hC0, 8'h01, 8'h01, 8'hC0, 0, "badop");
  endtask

  task automatic test_noise_and_drop;
    bit good;
    int seen0, alu0;
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_frame(8'h20, 8'h05, 8'h03, 8'h26, 0, "noise");
    tx_dmin = 8; tx_dmax = 10;
    seen0 = tx_seen;
    alu0 = alu_cnt;
    model_frame(8'h25, 8'h30, 8'h0C, 8'h25 ^ 8'h30 ^ 8'h0C, good);
    send_byte(8'hA5, 0);
    send_byte(8'h25, 0);
    send_byte(8'h30, 0);
    send_byte(8'h0C, 0);
    send_byte(8'h25 ^ 8'h30 ^ 8'h0C, 0);
    wait_seen(seen0 + 2, "drop");
    send_byte(8'hA5, 0);
    send_byte(8'h20, 0);
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_busy: got %b, expected 1 during response", o_busy);
    end
    wait_idle("drop");
    checks++;
    if (alu_cnt - alu0 != 1) begin
      errors++;
      $display("FAIL drop_alu_pulses: got %0d, expected 1", alu_cnt - alu0);
    end
    tx_dmin = 1; tx_dmax = 3;
    send_frame(8'h22, 8'h40, 8'h11, 8'h22 ^ 8'h40 ^ 8'h11, 0, "after_drop");
  endtask

  task automatic test_reset_in_wait;
    bit good;
    int seen0, n;
    tx_dmin = 15; tx_dmax = 15;
    seen0 = tx_seen;
    model_frame(8'h24, 8'hF0, 8'h3C, 8'h24 ^ 8'hF0 ^ 8'h3C, good);
    exp_q.delete(exp_q.size() - 1);
    send_byte(8'hA5, 0);
    send_byte(8'h24, 0);
    send_byte(8'hF0, 0);
    send_byte(8'h3C, 0);
    send_byte(8'h24 ^ 8'hF0 ^ 8'h3C, 0);
    wait_seen(seen0 + 2, "rstwait");
    hold_chk_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    @(negedge clk);
    check_zero_outputs("rstwait");
    n = 0;
    while (tx_active && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    hold_chk_en = 1'b1;
    checks++;
    if (tx_seen != seen0 + 2 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL rstwait_quiet: got %0d bytes busy=%b, expected %0d bytes busy=0",
               tx_seen - seen0, o_busy, 2);
    end
    tx_dmin = 1; tx_dmax = 4;
    send_frame(8'h20, 8'h05, 8'h03, 8'h26, 0, "after_rst");
  endtask

  task automatic test_back_to_back;
    tx_dmin = 1; tx_dmax = 1;
    send_frame(8'h26, 8'h5A, 8'hA5, 8'h26 ^ 8'h5A ^ 8'hA5, 0, "b2b0");
    send_frame(8'h27, 8'h00, 8'h00, 8'h27, 0, "b2b1");
    send_frame(8'h3F, 8'hFF, 8'hA5, 8'h3F ^ 8'hFF ^ 8'hA5, 0, "b2b2");
  endtask

  task automatic test_random_frames;
    logic [7:0] ops[6];
    logic [7:0] op, a, b, chk, nb;
    int nn;
    ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27};
    for (int k = 0; k < 16; k++) begin
      nn = $urandom_range(0, 2);
      for (int j = 0; j < nn; j++) begin
        do nb = 8'($urandom); while (nb == 8'hA5);
        send_byte(nb, 0);
      end
      case ($urandom_range(0, 3))
        0:       op = 8'($urandom);
        3:       op = {2'b00, 6'($urandom)};
        default: op = ops[$urandom_range(0, 5)];
      endcase
      a = 8'($urandom);
      b = 8'($urandom);
      chk = op ^ a ^ b;
      if ($urandom_range(0, 3) == 0) chk = chk ^ 8'($urandom_range(1, 255));
      tx_dmin = 1;
      tx_dmax = $urandom_range(1, 6);
      send_frame(op, a, b, chk, $urandom_range(0, 2), "rand");
    end
  endtask

`ifdef UART_SEQ_TIMEOUT_EN
  task automatic test_timeout;
    int err0, seen0;
    tx_dmin = 1; tx_dmax = 3;
    err0 = err_cnt;
    seen0 = tx_seen;
    send_byte(8'hA5, 0);
    send_byte(8'h20, 0);
    tick_n(32);
    repeat (6) @(negedge clk);
    checks++;
    if (err_cnt - err0 != 1) begin
      errors++;
      $display("FAIL timeout_err: got %0d pulse cycles, expected 1", err_cnt - err0);
    end
    checks++;
    if (o_busy !== 1'b0 || tx_seen != seen0) begin
      errors++;
      $display("FAIL timeout_abort: got busy=%b tx=%0d, expected busy=0 tx=0",
               o_busy, tx_seen - seen0);
    end
    begin
      bit good;
      int alu1, err1;
      model_frame(8'h20, 8'h05, 8'h03, 8'h26, good);
      alu1 = alu_cnt;
      err1 = err_cnt;
      send_byte(8'hA5, 0);
      send_byte(8'h20, 0);
      tick_n(31);
      send_byte(8'h05, 0);
      send_byte(8'h03, 0);
      send_byte(8'h26, 0);
      wait_idle("gap31");
      checks++;
      if (alu_cnt - alu1 != 1 || err_cnt - err1 != 0) begin
        errors++;
        $display("FAIL gap31_frame: got alu=%0d err=%0d, expected alu=1 err=0",
                 alu_cnt - alu1, err_cnt - err1);
      end
    end
  endtask
`endif

  initial begin
    i_rst = 1'b1;
    i_tick = 1'b0;
    i_rx_done = 1'b0;
    i_rx_data = 8'h00;
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_bad_opcode();
    test_noise_and_drop();
    test_reset_in_wait();
    test_back_to_back();
    test_random_frames();
`ifdef UART_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
